// File: rtl/scan_sequencer.sv
// Channel-scan sequencer: walks a latched 8-channel enable mask, holding each enabled channel
// for dwell+1 cycles, and drives the select {x,y,z} of the downstream 3-to-8 decoder.
// Optional feature: define SCAN_SEQ_PAUSE_EN to add the 'pause' input.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  output logic               x,
  output logic               y,
  output logic               z,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [7:0]           mask_r;
  logic [DWELL_W-1:0]   dwell_r;
  logic [DWELL_W-1:0]   cnt_r;
  logic                 mode_r;
  logic [2:0]           sel_r;
  logic                 valid_r;
  logic                 busy_r;
  logic                 done_r;
  logic [3:0]           next_s;
  logic                 hold_s;

  // Index of the lowest set bit; only meaningful for a non-zero mask.
  function automatic logic [2:0] first_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above 'after'.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] after);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (3'(i) > after)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign next_s = next_above(mask_r, sel_r);

`ifdef SCAN_SEQ_PAUSE_EN
  assign hold_s = pause;
`else
  assign hold_s = 1'b0;
`endif

  // Sequencer state, latched configuration, dwell counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mask_r  <= 8'd0;
      dwell_r <= {DWELL_W{1'b0}};
      mode_r  <= 1'b0;
      cnt_r   <= {DWELL_W{1'b0}};
      sel_r   <= 3'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start && !stop) begin
            mask_r  <= mask;
            dwell_r <= dwell;
            mode_r  <= mode;
            cnt_r   <= {DWELL_W{1'b0}};
            if (mask != 8'd0) begin
              state_r <= SCAN;
              sel_r   <= first_set(mask);
              valid_r <= 1'b1;
              busy_r  <= 1'b1;
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (stop) begin
            state_r <= IDLE;
            cnt_r   <= {DWELL_W{1'b0}};
            sel_r   <= 3'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (hold_s) begin
            cnt_r <= cnt_r;
          end else if (cnt_r == dwell_r) begin
            // Channel switch happens on the same edge the count wraps, so no gap cycles.
            cnt_r <= {DWELL_W{1'b0}};
            if (next_s[3]) begin
              sel_r <= next_s[2:0];
            end else if (mode_r) begin
              sel_r <= first_set(mask_r);
            end else begin
              state_r <= DONE;
              sel_r   <= 3'd0;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + DWELL_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          cnt_r   <= {DWELL_W{1'b0}};
          sel_r   <= 3'd0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {DWELL_W{1'b0}};
          sel_r   <= 3'd0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign x     = sel_r[2];
  assign y     = sel_r[1];
  assign z     = sel_r[0];
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: a per-cycle schedule model plus directed literal checks.
// Build with SCAN_SEQ_PAUSE_EN defined to also exercise the pause input.
module tb_scan_sequencer;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic          mode  = 1'b0;
  logic [7:0]    mask  = 8'd0;
  logic [DW-1:0] dwell = '0;
  logic          pause = 1'b0;
  logic          x, y, z, valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .mask  (mask),
    .dwell (dwell),
`ifdef SCAN_SEQ_PAUSE_EN
    .pause (pause),
`endif
    .x     (x),
    .y     (y),
    .z     (z),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  // Model: kind 0 = idle, 1 = scanning channel m_ch, 2 = done pulse.
  // A scan is a precomputed schedule: every enabled channel listed dwell+1 times.
  int         m_kind = 0;
  int         m_ch   = 0;
  int         m_sched[$];
  logic [7:0] m_mask = 8'd0;
  int         m_dwell = 0;
  logic       m_mode = 1'b0;

  task automatic m_fill();
    for (int c = 0; c < 8; c++)
      if (m_mask[c]) for (int k = 0; k <= m_dwell; k++) m_sched.push_back(c);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_kind = 0; m_ch = 0; m_sched.delete();
      end else if (m_kind == 0) begin
        if (start && !stop) begin
          m_mask = mask; m_dwell = int'(dwell); m_mode = mode;
          if (mask == 8'd0) m_kind = 2;
          else begin m_fill(); m_ch = m_sched.pop_front(); m_kind = 1; end
        end
      end else if (m_kind == 1) begin
        if (stop) begin
          m_kind = 0; m_sched.delete();
        end else if (!pause) begin
          if (m_sched.size() > 0) m_ch = m_sched.pop_front();
          else if (m_mode) begin m_fill(); m_ch = m_sched.pop_front(); end
          else m_kind = 2;
        end
      end else begin
        m_kind = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [5:0] got, exp;
    forever begin
      @(negedge clk);
      got = {x, y, z, valid, busy, done};
      exp = {(m_kind == 1) ? 3'(m_ch) : 3'd0, m_kind == 1, m_kind == 1, m_kind == 2};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got {sel,v,b,d}=%b expected %b", $time, got, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] sel();
    return {x, y, z};
  endfunction

  // Returns at the negedge where the first scan cycle is visible.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int exp2[8] = '{0, 0, 2, 2, 5, 5, 7, 7};
    int exp5[6] = '{2, 2, 2, 3, 3, 3};
    int cnt;

    #12;
    chk("reset_outputs", {x, y, z, valid, busy, done}, 6'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-scan
    mask = 8'hFF; dwell = 8'd3; mode = 1'b1;
    pulse_start();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {x, y, z, valid, busy, done}, 6'd0);
    @(negedge clk); rst_n = 1'b1;
    mode = 1'b0; dwell = 8'd0; mask = 8'h06;
    pulse_start();
    chk("post_reset_first_ch", {sel(), valid}, {3'd1, 1'b1});
    repeat (3) @(negedge clk);

    // Single sweep over 1010_0101 with dwell=1
    mask = 8'b1010_0101; dwell = 8'd1; mode = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      chk("sweep_sel", {29'd0, sel()}, exp2[i]);
      chk("sweep_valid", valid, 1);
      @(negedge clk);
    end
    chk("sweep_done", {valid, busy, done}, 3'b001);
    @(negedge clk);
    chk("sweep_idle", {valid, busy, done}, 3'b000);

    // Continuous 0,7,0,7 then stop
    mask = 8'h81; dwell = 8'd0; mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("cont_sel", {29'd0, sel()}, (i % 2 == 0) ? 0 : 7);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_idle", {sel(), valid, busy, done}, 6'd0);
    repeat (3) begin @(negedge clk); chk("stop_no_done", done, 0); end

    // Empty mask, then start+stop together
    mask = 8'h00; mode = 1'b0;
    pulse_start();
    chk("empty_done", {valid, done}, 2'b01);
    @(negedge clk);
    chk("empty_after", {valid, done}, 2'b00);
    mask = 8'hFF; start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", {valid, busy, done}, 3'b000);

    // Mask change and re-start mid-scan ignored
    mask = 8'h0C; dwell = 8'd2; mode = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk("restart_sel", {29'd0, sel()}, exp5[i]);
      if (i == 1) begin mask = 8'hFF; dwell = 8'd0; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("restart_done", done, 1);
    repeat (2) @(negedge clk);

`ifdef SCAN_SEQ_PAUSE_EN
    // Pause 5 cycles on channel 4
    mask = 8'h10; dwell = 8'd2; mode = 1'b0;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid && sel() == 3'd4) cnt++;
      else break;
      if (i == 0) pause = 1'b1;
      if (i == 5) pause = 1'b0;
      @(negedge clk);
    end
    pause = 1'b0;
    chk("pause_hold_cycles", cnt, 8);
    repeat (2) @(negedge clk);
    pulse_start();
    pause = 1'b1; stop = 1'b1;
    @(negedge clk); pause = 1'b0; stop = 1'b0;
    chk("pause_stop_idle", {valid, busy, done}, 3'b000);
`else
    cnt = 0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
